// File: rtl/ifu.sv
// ifu: instruction fetch -- PC register, 1024x32 ROM mapped at 0x00003000, ext-mode decode, next-PC select.
// Define IFU_DELAY_SLOT_EN to give every taken redirect a one-instruction delay slot.
module ifu #(
   parameter logic [1023:0][31:0] ROM_INIT = '0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        br_taken,
   input  logic        j_taken,
   input  logic        jr_taken,
   input  logic [31:0] ra,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic [15:0] imm,
   output logic [1:0]  EOp
);

   localparam logic [31:0] PC_BASE = 32'h0000_3000;
   localparam logic [31:0] PC_LAST = 32'h0000_3ffc;

   logic [31:0] pc_r;
   logic [31:0] instr_s;
   logic [9:0]  idx_s;
   logic [31:0] pc4_s;
   logic [31:0] br_tgt_s;
   logic [31:0] j_tgt_s;
   logic [31:0] redir_tgt_s;

   function automatic logic [1:0] eop_decode(input logic [5:0] op);
      logic [1:0] mode;
      case (op)
         6'h0c, 6'h0d, 6'h0e: mode = 2'd1;
         6'h0f:               mode = 2'd2;
         6'h04, 6'h05:        mode = 2'd3;
         default:             mode = 2'd0;
      endcase
      return mode;
   endfunction

   assign idx_s    = pc_r[11:2] - PC_BASE[11:2];
   assign pc4_s    = pc_r + 32'd4;
   assign br_tgt_s = pc4_s + {{14{instr_s[15]}}, instr_s[15:0], 2'b00};
   assign j_tgt_s  = {pc4_s[31:28], instr_s[25:0], 2'b00};

   // ROM read; addresses outside the mapped window fetch zero
   always_comb begin
      instr_s = 32'h0000_0000;
      if ((pc_r >= PC_BASE) && (pc_r <= PC_LAST)) begin
         instr_s = ROM_INIT[idx_s];
      end else begin
         instr_s = 32'h0000_0000;
      end
   end

   // Redirect target by priority jr > j > br, falling back to sequential
   always_comb begin
      redir_tgt_s = pc4_s;
      if (jr_taken) begin
         redir_tgt_s = ra;
      end else if (j_taken) begin
         redir_tgt_s = j_tgt_s;
      end else if (br_taken) begin
         redir_tgt_s = br_tgt_s;
      end else begin
         redir_tgt_s = pc4_s;
      end
   end

`ifdef IFU_DELAY_SLOT_EN
   typedef enum logic [0:0] {RUN = 1'b0, SLOT = 1'b1} state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [31:0] tgt_r;
   logic [31:0] tgt_nxt_s;
   logic [31:0] pc_nxt_s;
   logic        redir_s;

   assign redir_s = jr_taken | j_taken | br_taken;

   // State, pending target and PC registers; a stall freezes all of them
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= RUN;
         tgt_r   <= 32'h0000_0000;
         pc_r    <= PC_BASE;
      end else if (en) begin
         state_r <= state_nxt_s;
         tgt_r   <= tgt_nxt_s;
         pc_r    <= pc_nxt_s;
      end
   end

   // Next state: a redirect opens the slot, the following advance closes it
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         RUN: begin
            if (redir_s) state_nxt_s = SLOT;
            else         state_nxt_s = RUN;
         end
         SLOT:    state_nxt_s = RUN;
         default: state_nxt_s = RUN;
      endcase
   end

   // Next PC and pending target; requests seen while in the slot are dropped
   always_comb begin
      pc_nxt_s  = pc4_s;
      tgt_nxt_s = tgt_r;
      case (state_r)
         RUN: begin
            pc_nxt_s = pc4_s;
            if (redir_s) tgt_nxt_s = redir_tgt_s;
            else         tgt_nxt_s = 32'h0000_0000;
         end
         SLOT: begin
            pc_nxt_s  = tgt_r;
            tgt_nxt_s = 32'h0000_0000;
         end
         default: begin
            pc_nxt_s  = pc4_s;
            tgt_nxt_s = 32'h0000_0000;
         end
      endcase
   end
`else
   // PC register: reset wins, a stall holds, otherwise take the selected target
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r <= PC_BASE;
      end else if (en) begin
         pc_r <= redir_tgt_s;
      end
   end
`endif

   assign pc    = pc_r;
   assign instr = instr_s;
   assign imm   = instr_s[15:0];
   assign EOp   = eop_decode(instr_s[31:26]);

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: two instances with different ROM images share all inputs.
// Slot-specific expectations are enabled when IFU_DELAY_SLOT_EN is defined.
module tb_ifu;

   function automatic logic [1023:0][31:0] prog(input bit alt);
      logic [1023:0][31:0] m;
      m          = '0;
      m[0]       = alt ? 32'h1000_0003 : 32'h3401_1234;
      m[1]       = 32'h1400_0000;
      m[2]       = alt ? 32'h1000_0004 : 32'h1000_ffff;
      m[3]       = 32'h0800_0c10;
      m[16]      = 32'h3c01_abcd;
      m[64]      = 32'h0800_0c10;
      m[1023]    = 32'h3800_5555;
      return m;
   endfunction

   localparam logic [1023:0][31:0] ROM_A = prog(1'b0);
   localparam logic [1023:0][31:0] ROM_B = prog(1'b1);

   logic        clk = 1'b0;
   logic        reset, en, br_taken, j_taken, jr_taken;
   logic [31:0] ra;
   logic [31:0] pc_a, instr_a, pc_b, instr_b;
   logic [15:0] imm_a, imm_b;
   logic [1:0]  eop_a, eop_b;
   int          checks = 0;
   int          errors = 0;

   ifu #(.ROM_INIT(ROM_A)) u_a (
      .clk(clk), .reset(reset), .en(en), .br_taken(br_taken), .j_taken(j_taken),
      .jr_taken(jr_taken), .ra(ra), .pc(pc_a), .instr(instr_a), .imm(imm_a), .EOp(eop_a)
   );

   ifu #(.ROM_INIT(ROM_B)) u_b (
      .clk(clk), .reset(reset), .en(en), .br_taken(br_taken), .j_taken(j_taken),
      .jr_taken(jr_taken), .ra(ra), .pc(pc_b), .instr(instr_b), .imm(imm_b), .EOp(eop_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_taken();
      br_taken = 1'b0;
      j_taken  = 1'b0;
      jr_taken = 1'b0;
   endtask

   task automatic do_reset();
      clear_taken();
      en    = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      en = 1'b0; br_taken = 1'b1; j_taken = 1'b1; jr_taken = 1'b1; ra = 32'h0000_5000;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_taken();
      checks++; if (pc_a !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_a, 32'h0000_3000); end
      checks++; if (instr_a !== 32'h3401_1234) begin errors++; $display("FAIL reset_instr got %h exp %h", instr_a, 32'h3401_1234); end
      checks++; if (imm_a !== 16'h1234) begin errors++; $display("FAIL reset_imm got %h exp %h", imm_a, 16'h1234); end
      checks++; if (eop_a !== 2'd1) begin errors++; $display("FAIL reset_eop got %0d exp %0d", eop_a, 2'd1); end
      checks++; if (pc_b !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc_b got %h exp %h", pc_b, 32'h0000_3000); end
      checks++; if (instr_b !== 32'h1000_0003) begin errors++; $display("FAIL reset_instr_b got %h exp %h", instr_b, 32'h1000_0003); end
      checks++; if (imm_b !== 16'h0003) begin errors++; $display("FAIL reset_imm_b got %h exp %h", imm_b, 16'h0003); end
      checks++; if (eop_b !== 2'd3) begin errors++; $display("FAIL reset_eop_b got %0d exp %0d", eop_b, 2'd3); end
   endtask

   task automatic test_seq_stall();
      en = 1'b1;
      tick();
      checks++; if (pc_a !== 32'h0000_3004) begin errors++; $display("FAIL seq1_pc got %h exp %h", pc_a, 32'h0000_3004); end
      checks++; if (eop_a !== 2'd3) begin errors++; $display("FAIL bne_eop got %0d exp %0d", eop_a, 2'd3); end
      tick();
      checks++; if (instr_a !== 32'h1000_ffff) begin errors++; $display("FAIL seq2_instr got %h exp %h", instr_a, 32'h1000_ffff); end
      tick();
      checks++; if (pc_a !== 32'h0000_300c) begin errors++; $display("FAIL seq3_pc got %h exp %h", pc_a, 32'h0000_300c); end
      en = 1'b0; br_taken = 1'b1; jr_taken = 1'b1; ra = 32'h0000_3100;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (pc_a !== 32'h0000_300c) begin errors++; $display("FAIL stall_pc got %h exp %h", pc_a, 32'h0000_300c); end
      end
      clear_taken();
   endtask

   task automatic test_branch();
      do_reset();
      tick();
      tick();
      checks++; if (instr_a !== 32'h1000_ffff) begin errors++; $display("FAIL beq_instr got %h exp %h", instr_a, 32'h1000_ffff); end
      checks++; if (eop_a !== 2'd3) begin errors++; $display("FAIL beq_eop got %0d exp %0d", eop_a, 2'd3); end
      br_taken = 1'b1;
      tick();
      br_taken = 1'b0;
`ifdef IFU_DELAY_SLOT_EN
      checks++; if (pc_a !== 32'h0000_300c) begin errors++; $display("FAIL beq_slot_pc got %h exp %h", pc_a, 32'h0000_300c); end
      tick();
`endif
      checks++; if (pc_a !== 32'h0000_3008) begin errors++; $display("FAIL beq_self_pc got %h exp %h", pc_a, 32'h0000_3008); end
      checks++; if (pc_b !== 32'h0000_301c) begin errors++; $display("FAIL beq_fwd_pc got %h exp %h", pc_b, 32'h0000_301c); end
   endtask

   task automatic test_priority();
      tick();
      checks++; if (instr_a !== 32'h0800_0c10) begin errors++; $display("FAIL j_instr got %h exp %h", instr_a, 32'h0800_0c10); end
      jr_taken = 1'b1; j_taken = 1'b1; br_taken = 1'b1; ra = 32'h0000_3100;
      tick();
      clear_taken();
`ifdef IFU_DELAY_SLOT_EN
      checks++; if (pc_a !== 32'h0000_3010) begin errors++; $display("FAIL prio_slot_pc got %h exp %h", pc_a, 32'h0000_3010); end
      tick();
`endif
      checks++; if (pc_a !== 32'h0000_3100) begin errors++; $display("FAIL prio_jr_pc got %h exp %h", pc_a, 32'h0000_3100); end
      j_taken = 1'b1;
      tick();
      j_taken = 1'b0;
`ifdef IFU_DELAY_SLOT_EN
      checks++; if (pc_a !== 32'h0000_3104) begin errors++; $display("FAIL j_slot_pc got %h exp %h", pc_a, 32'h0000_3104); end
      tick();
`endif
      checks++; if (pc_a !== 32'h0000_3040) begin errors++; $display("FAIL j_pc got %h exp %h", pc_a, 32'h0000_3040); end
   endtask

   task automatic test_lui_range();
      checks++; if (instr_a !== 32'h3c01_abcd) begin errors++; $display("FAIL lui_instr got %h exp %h", instr_a, 32'h3c01_abcd); end
      checks++; if (eop_a !== 2'd2) begin errors++; $display("FAIL lui_eop got %0d exp %0d", eop_a, 2'd2); end
      checks++; if (imm_a !== 16'habcd) begin errors++; $display("FAIL lui_imm got %h exp %h", imm_a, 16'habcd); end
      jr_taken = 1'b1; ra = 32'h0000_4000;
      tick();
      jr_taken = 1'b0;
`ifdef IFU_DELAY_SLOT_EN
      checks++; if (pc_a !== 32'h0000_3044) begin errors++; $display("FAIL jr_slot_pc got %h exp %h", pc_a, 32'h0000_3044); end
      tick();
`endif
      checks++; if (pc_a !== 32'h0000_4000) begin errors++; $display("FAIL jr_hi_pc got %h exp %h", pc_a, 32'h0000_4000); end
      checks++; if (instr_a !== 32'h0000_0000) begin errors++; $display("FAIL oor_hi_instr got %h exp %h", instr_a, 32'h0000_0000); end
      checks++; if (eop_a !== 2'd0) begin errors++; $display("FAIL oor_hi_eop got %0d exp %0d", eop_a, 2'd0); end
      checks++; if (imm_a !== 16'h0000) begin errors++; $display("FAIL oor_hi_imm got %h exp %h", imm_a, 16'h0000); end
      jr_taken = 1'b1; ra = 32'h0000_2ffc;
      tick();
      jr_taken = 1'b0;
`ifdef IFU_DELAY_SLOT_EN
      tick();
`endif
      checks++; if (instr_a !== 32'h0000_0000) begin errors++; $display("FAIL oor_lo_instr got %h exp %h", instr_a, 32'h0000_0000); end
      jr_taken = 1'b1; ra = 32'h0000_3ffc;
      tick();
      jr_taken = 1'b0;
`ifdef IFU_DELAY_SLOT_EN
      checks++; if (pc_a !== 32'h0000_3000) begin errors++; $display("FAIL jr_lo_slot_pc got %h exp %h", pc_a, 32'h0000_3000); end
      tick();
`endif
      checks++; if (instr_a !== 32'h3800_5555) begin errors++; $display("FAIL last_instr got %h exp %h", instr_a, 32'h3800_5555); end
      checks++; if (eop_a !== 2'd1) begin errors++; $display("FAIL last_eop got %0d exp %0d", eop_a, 2'd1); end
      jr_taken = 1'b1; ra = 32'hffff_fffc;
      tick();
      jr_taken = 1'b0;
`ifdef IFU_DELAY_SLOT_EN
      tick();
`endif
      checks++; if (pc_a !== 32'hffff_fffc) begin errors++; $display("FAIL jr_top_pc got %h exp %h", pc_a, 32'hffff_fffc); end
      tick();
      checks++; if (pc_a !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc got %h exp %h", pc_a, 32'h0000_0000); end
   endtask

   task automatic test_stall_reset();
      en = 1'b0; j_taken = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; j_taken = 1'b0;
      checks++; if (pc_a !== 32'h0000_3000) begin errors++; $display("FAIL stall_reset_pc got %h exp %h", pc_a, 32'h0000_3000); end
      tick();
      checks++; if (pc_a !== 32'h0000_3000) begin errors++; $display("FAIL post_reset_hold got %h exp %h", pc_a, 32'h0000_3000); end
   endtask

`ifdef IFU_DELAY_SLOT_EN
   task automatic test_delay_slot();
      do_reset();
      br_taken = 1'b1;
      tick();
      br_taken = 1'b0;
      checks++; if (pc_b !== 32'h0000_3004) begin errors++; $display("FAIL ds_slot_pc got %h exp %h", pc_b, 32'h0000_3004); end
      tick();
      checks++; if (pc_b !== 32'h0000_3010) begin errors++; $display("FAIL ds_tgt_pc got %h exp %h", pc_b, 32'h0000_3010); end
      do_reset();
      br_taken = 1'b1;
      tick();
      br_taken = 1'b0; en = 1'b0;
      tick();
      tick();
      checks++; if (pc_b !== 32'h0000_3004) begin errors++; $display("FAIL ds_stall_pc got %h exp %h", pc_b, 32'h0000_3004); end
      en = 1'b1;
      tick();
      checks++; if (pc_b !== 32'h0000_3010) begin errors++; $display("FAIL ds_stall_tgt got %h exp %h", pc_b, 32'h0000_3010); end
      do_reset();
      br_taken = 1'b1;
      tick();
      br_taken = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (pc_b !== 32'h0000_3000) begin errors++; $display("FAIL ds_reset_pc got %h exp %h", pc_b, 32'h0000_3000); end
      tick();
      checks++; if (pc_b !== 32'h0000_3004) begin errors++; $display("FAIL ds_reset_seq1 got %h exp %h", pc_b, 32'h0000_3004); end
      tick();
      checks++; if (pc_b !== 32'h0000_3008) begin errors++; $display("FAIL ds_reset_seq2 got %h exp %h", pc_b, 32'h0000_3008); end
   endtask
`endif

   initial begin
      reset = 1'b0; en = 1'b0; ra = 32'h0000_0000;
      clear_taken();
      test_reset();
      test_seq_stall();
      test_branch();
      test_priority();
      test_lui_range();
      test_stall_reset();
`ifdef IFU_DELAY_SLOT_EN
      test_delay_slot();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
